// File: rtl/uart_framed.sv
// Framed UART: configurable data width, parity and stop bits.
// Byte-wide valid/ready on both directions, flagged RX errors.
module uart_framed #(
  parameter int BAUDSEL   = 10,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int CMAX = 2 * BAUDSEL;
  localparam int CW   = $clog2(CMAX + 2);
  localparam logic [CW-1:0] CTOP  = CW'(CMAX);
  localparam logic [CW-1:0] CMID  = CW'(BAUDSEL);
  localparam logic [CW-1:0] CONE  = CW'(1);
  localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
  localparam logic          SLAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK, R_ERR
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_state_t;

  // ---------------- RX ----------------
  logic rx_meta, rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  rx_state_t            rx_st, rx_nx;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_bit;
  logic                 rx_stp;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pbit, rx_pe;
  logic                 rx_samp, rx_pexp;
  logic                 rx_done, rx_fe, rx_bk;

  assign rx_samp = (rx_cnt == CTOP);
  assign rx_pexp = (PARITY == 2) ? ^rx_sh : ~^rx_sh;

  always_comb begin
    rx_nx   = rx_st;
    rx_done = 1'b0;
    rx_fe   = 1'b0;
    rx_bk   = 1'b0;
    unique case (rx_st)
      R_IDLE:  if (!rxs) rx_nx = R_START;
      R_START: if (rx_samp) rx_nx = rxs ? R_IDLE : R_DATA;
      R_DATA:
        if (rx_samp && rx_bit == DLAST)
          rx_nx = (PARITY != 0) ? R_PAR : R_STOP;
      R_PAR:   if (rx_samp) rx_nx = R_STOP;
      R_STOP:
        if (rx_samp) begin
          if (rxs) begin
            if (rx_stp == SLAST) begin
              rx_nx   = R_IDLE;
              rx_done = 1'b1;
            end
          end else if (rx_sh == '0 && !rx_pbit) begin
            rx_nx = R_BRK;
          end else begin
            rx_nx = R_ERR;
            rx_fe = 1'b1;
          end
        end
      R_BRK:
        if (rx_samp && rxs) begin
          rx_nx = R_IDLE;
          rx_bk = 1'b1;
        end
      R_ERR:   if (rx_samp && rxs) rx_nx = R_IDLE;
      default: rx_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st   <= R_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_stp  <= 1'b0;
      rx_sh   <= '0;
      rx_pbit <= 1'b0;
      rx_pe   <= 1'b0;
    end else begin
      rx_st <= rx_nx;
      if (rx_st == R_IDLE) begin
        // preload so the first sample lands mid start bit
        rx_cnt  <= CMID;
        rx_bit  <= '0;
        rx_stp  <= 1'b0;
        rx_sh   <= '0;
        rx_pbit <= 1'b0;
        rx_pe   <= 1'b0;
      end else begin
        rx_cnt <= rx_samp ? '0 : rx_cnt + CONE;
        if (rx_samp) begin
          unique case (rx_st)
            R_DATA: begin
              rx_sh  <= {rxs, rx_sh[DATA_BITS-1:1]};
              rx_bit <= rx_bit + 4'd1;
            end
            R_PAR: begin
              rx_pbit <= rxs;
              rx_pe   <= (rxs != rx_pexp);
            end
            R_STOP:  rx_stp <= rx_stp + 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err <= rx_fe;
      rx_break     <= rx_bk;
      rx_overrun   <= rx_done && rx_valid && !rx_ready;
      if (rx_done && (!rx_valid || rx_ready)) begin
        rx_valid      <= 1'b1;
        rx_data       <= rx_sh;
        rx_parity_err <= rx_pe;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // ---------------- TX ----------------
  tx_state_t            tx_st, tx_nx;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_bit;
  logic                 tx_stp;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_samp;

  assign tx_samp  = (tx_cnt == CTOP);
  assign tx_ready = (tx_st == T_IDLE);

  always_comb begin
    tx_nx = tx_st;
    tx    = 1'b1;
    unique case (tx_st)
      T_IDLE:  if (tx_valid) tx_nx = T_START;
      T_START: begin
        tx = 1'b0;
        if (tx_samp) tx_nx = T_DATA;
      end
      T_DATA: begin
        tx = tx_sh[0];
        if (tx_samp && tx_bit == DLAST)
          tx_nx = (PARITY != 0) ? T_PAR : T_STOP;
      end
      T_PAR: begin
        tx = tx_par;
        if (tx_samp) tx_nx = T_STOP;
      end
      T_STOP:
        if (tx_samp && tx_stp == SLAST) tx_nx = T_IDLE;
      default: tx_nx = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_stp <= 1'b0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      if (tx_st == T_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        tx_stp <= 1'b0;
        if (tx_valid) begin
          tx_sh  <= tx_data;
          tx_par <= (PARITY == 2) ? ^tx_data : ~^tx_data;
        end
      end else begin
        tx_cnt <= tx_samp ? '0 : tx_cnt + CONE;
        if (tx_samp) begin
          unique case (tx_st)
            T_DATA: begin
              tx_sh  <= tx_sh >> 1;
              tx_bit <= tx_bit + 4'd1;
            end
            T_STOP:  tx_stp <= tx_stp + 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
